// File: rtl/pipe_pkg.sv
// Shared types and default stage indices for the pipeline hazard controller.
package pipe_pkg;

    // Widest register address a shadow entry can hold; narrower cores zero-extend.
    localparam int unsigned MAX_REG_AW = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [MAX_REG_AW-1:0] wr_addr;
        logic                  is_load;
    } shadow_t;

    localparam int unsigned STG_F = 0;
    localparam int unsigned STG_D = 1;
    localparam int unsigned STG_E = 2;
    localparam int unsigned STG_M = 3;
    localparam int unsigned STG_W = 4;

    localparam int unsigned SEL_REGFILE = 0;

endpackage

// File: rtl/fwd_match.sv
// Priority search of the post-decode shadow for one decode operand:
// the youngest matching producer decides between forwarding and a stall.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned DEC_STAGE      = 1,
    parameter int unsigned ALU_FWD_STAGE  = 3,
    parameter int unsigned LOAD_FWD_STAGE = 4,
    parameter int unsigned SEL_W          = $clog2(NUM_STAGES)
) (
    input  shadow_t               shadow_i [DEC_STAGE+1:NUM_STAGES-1],
    input  logic [MAX_REG_AW-1:0] reg_i,
    input  logic                  use_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  hazard_o
);

    logic found;

    always_comb begin
        sel_o    = SEL_W'(SEL_REGFILE);
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int unsigned k = DEC_STAGE + 1; k < NUM_STAGES; k++) begin
            if (!found && use_i && (reg_i != '0) && shadow_i[k].valid &&
                shadow_i[k].wr_en && (shadow_i[k].wr_addr == reg_i)) begin
                found = 1'b1;
                if (k >= (shadow_i[k].is_load ? LOAD_FWD_STAGE : ALU_FWD_STAGE)) begin
                    sel_o = SEL_W'(k);
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: shadow tracking of in-flight writers, stage enables/flushes,
// decode forwarding selects and a saturating data-stall counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES        = 5,
    parameter int unsigned REG_AW            = 5,
    parameter int unsigned DEC_STAGE         = STG_D,
    parameter int unsigned ALU_FWD_STAGE     = STG_M,
    parameter int unsigned LOAD_FWD_STAGE    = STG_W,
    parameter int unsigned FLUSH_ON_REDIRECT = 0,
    parameter int unsigned SEL_W             = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wait,
    input  logic                  d_wait,
    input  logic                  dec_valid,
    input  logic [REG_AW-1:0]     dec_rs,
    input  logic [REG_AW-1:0]     dec_rt,
    input  logic                  dec_use_rs,
    input  logic                  dec_use_rt,
    input  logic                  dec_wr_en,
    input  logic [REG_AW-1:0]     dec_wr_addr,
    input  logic                  dec_is_load,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [31:0]           stall_cnt
);

    localparam int unsigned FIRST = DEC_STAGE + 1;

    shadow_t               shadow_q [FIRST:NUM_STAGES-1];
    shadow_t               shadow_d [FIRST:NUM_STAGES-1];
    shadow_t               dec_entry;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic [MAX_REG_AW-1:0] rs_ext, rt_ext;
    logic                  rs_hazard, rt_hazard;
    logic                  bus_wait, data_hazard;

    assign rs_ext      = MAX_REG_AW'(dec_rs);
    assign rt_ext      = MAX_REG_AW'(dec_rt);
    assign bus_wait    = i_wait | d_wait;
    assign data_hazard = dec_valid & (rs_hazard | rt_hazard);
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        dec_entry = '{valid:   dec_valid,
                      wr_en:   dec_valid & dec_wr_en,
                      wr_addr: MAX_REG_AW'(dec_wr_addr),
                      is_load: dec_valid & dec_is_load};
    end

    fwd_match #(
        .NUM_STAGES    (NUM_STAGES),
        .DEC_STAGE     (DEC_STAGE),
        .ALU_FWD_STAGE (ALU_FWD_STAGE),
        .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
        .SEL_W         (SEL_W)
    ) u_fwd_rs (
        .shadow_i(shadow_q),
        .reg_i   (rs_ext),
        .use_i   (dec_use_rs),
        .sel_o   (fwd_rs_sel),
        .hazard_o(rs_hazard)
    );

    fwd_match #(
        .NUM_STAGES    (NUM_STAGES),
        .DEC_STAGE     (DEC_STAGE),
        .ALU_FWD_STAGE (ALU_FWD_STAGE),
        .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
        .SEL_W         (SEL_W)
    ) u_fwd_rt (
        .shadow_i(shadow_q),
        .reg_i   (rt_ext),
        .use_i   (dec_use_rt),
        .sel_o   (fwd_rt_sel),
        .hazard_o(rt_hazard)
    );

    always_comb begin
        stage_en    = '1;
        stage_flush = '0;
        stall_cnt_d = stall_cnt_q;
        if (reset) begin
            stage_en    = '0;
            stage_flush = '1;
        end else if (bus_wait) begin
            stage_en = '0;
        end else if (data_hazard) begin
            // Hold fetch..decode, let the rest drain, inject a bubble behind decode.
            for (int unsigned k = 0; k <= DEC_STAGE; k++) begin
                stage_en[k] = 1'b0;
            end
            stage_flush[FIRST] = 1'b1;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end else if (FLUSH_ON_REDIRECT != 0) begin
            stage_flush[0] = redirect & dec_valid;
        end
    end

    always_comb begin
        shadow_d[FIRST] = shadow_q[FIRST];
        if (stage_en[FIRST]) begin
            shadow_d[FIRST] = stage_flush[FIRST] ? '0 : dec_entry;
        end
        for (int unsigned k = FIRST + 1; k < NUM_STAGES; k++) begin
            shadow_d[k] = shadow_q[k];
            if (stage_en[k]) begin
                shadow_d[k] = stage_flush[k] ? '0 : shadow_q[k-1];
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int unsigned k = FIRST; k < NUM_STAGES; k++) begin
            stage_valid[k] = shadow_q[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = FIRST; k < NUM_STAGES; k++) begin
                shadow_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
